// File: rtl/mul_arb_sched.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier among NREQ requesters.
// A valid/tag shift register matches the multiplier latency and steers each product back.
module mul_arb_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CW      = $clog2(MUL_LAT + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic                 mul_vld,
  output logic [31:0]          mul_in1,
  output logic [31:0]          mul_in2,
  input  logic [63:0]          mul_res,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [63:0]          rsp_res,
  output logic [CW-1:0]        inflight,
  output logic                 idle
);

  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NST = MUL_LAT + 1;
  localparam int unsigned DW  = 32;
  localparam int unsigned PW  = 64;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic            mul_vld_q, mul_vld_d;
  logic [DW-1:0]   mul_in1_q, mul_in1_d;
  logic [DW-1:0]   mul_in2_q, mul_in2_d;
  logic [NST-1:0]  tv_q, tv_d;
  logic [IW-1:0]   tid_q [NST];
  logic [IW-1:0]   tid_d [NST];
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]   rsp_res_q, rsp_res_d;
  logic [CW-1:0]   inflight_q, inflight_d;

  logic            gfound_c;
  logic [IW-1:0]   gidx_c;
  logic            xfer_c;
  logic            retire_c;

  // First valid requester at or after ptr_q, with wrap-around.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    gfound_c = 1'b0;
    gidx_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!gfound_c && req_valid[IW'(idx)]) begin
        gfound_c = 1'b1;
        gidx_c   = IW'(idx);
      end
    end
  end

  // hold and rst gate the grant combinationally so they act in the same cycle.
  assign xfer_c    = gfound_c & ~hold & ~rst;
  assign req_ready = xfer_c ? (NREQ'(1) << gidx_c) : '0;
  assign retire_c  = tv_q[NST-1];

  always_comb begin
    ptr_d       = ptr_q;
    mul_vld_d   = xfer_c;
    mul_in1_d   = mul_in1_q;
    mul_in2_d   = mul_in2_q;
    tv_d        = {tv_q[NST-2:0], xfer_c};
    tid_d[0]    = gidx_c;
    for (int unsigned k = 1; k < NST; k++) begin
      tid_d[k] = tid_q[k-1];
    end
    rsp_valid_d = '0;
    rsp_res_d   = rsp_res_q;
    inflight_d  = inflight_q;

    if (xfer_c) begin
      ptr_d     = (gidx_c == IW'(NREQ - 1)) ? '0 : gidx_c + IW'(1);
      mul_in1_d = req_a[DW*gidx_c +: DW];
      mul_in2_d = req_b[DW*gidx_c +: DW];
    end

    // The tag leaving the last stage lines up with this cycle's product.
    if (retire_c) begin
      rsp_valid_d = NREQ'(1) << tid_q[NST-1];
      rsp_res_d   = mul_res;
    end

    case ({xfer_c, retire_c})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mul_vld_q   <= 1'b0;
      mul_in1_q   <= '0;
      mul_in2_q   <= '0;
      tv_q        <= '0;
      for (int unsigned k = 0; k < NST; k++) begin
        tid_q[k] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      inflight_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_vld_q   <= mul_vld_d;
      mul_in1_q   <= mul_in1_d;
      mul_in2_q   <= mul_in2_d;
      tv_q        <= tv_d;
      for (int unsigned k = 0; k < NST; k++) begin
        tid_q[k] <= tid_d[k];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      inflight_q  <= inflight_d;
    end
  end

  assign mul_vld   = mul_vld_q;
  assign mul_in1   = mul_in1_q;
  assign mul_in2   = mul_in2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign inflight  = inflight_q;
  assign idle      = (inflight_q == '0) && (req_valid == '0);

endmodule

// File: tb/tb_mul_arb_sched.sv
// Bench for mul_arb_sched: vector table, directed corner sequences and random traffic
// checked against a scoreboard of expected responses keyed by delivery edge.
module tb_mul_arb_sched;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned CW      = $clog2(MUL_LAT + 2);
  localparam int          LAT     = MUL_LAT;
  localparam int          NR      = NREQ;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic                 mul_vld;
  logic [31:0]          mul_in1;
  logic [31:0]          mul_in2;
  logic [63:0]          mul_res;
  logic [NREQ-1:0]      rsp_valid;
  logic [63:0]          rsp_res;
  logic [CW-1:0]        inflight;
  logic                 idle;

  mul_arb_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_vld(mul_vld), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_res(mul_res),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product visible MUL_LAT edges after the operands were presented.
  logic [63:0] mp [MUL_LAT];
  always_ff @(posedge clk) begin
    mp[0] <= 64'(mul_in1) * 64'(mul_in2);
    for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
  end
  assign mul_res = mp[MUL_LAT-1];

  typedef struct { int due; int id; logic [63:0] prod; } exp_t;
  typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [63:0] p; } vec_t;

  exp_t            m_q[$];
  int              m_ptr;
  int              ecnt;
  int              last_grant;
  logic            e_mvld;
  logic [31:0]     e_in1, e_in2;
  logic [NREQ-1:0] e_rv;
  logic [63:0]     e_rres;
  logic [NREQ-1:0] obs_rv;
  logic [63:0]     obs_rres;
  int              n_chk = 0;
  int              n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic new_ops(input int i);
    logic [31:0] a, b;
    case ($urandom % 6)
      0: a = 32'hFFFF_FFFF;
      1: a = 32'h0;
      2: a = 32'h8000_0000;
      default: a = $urandom;
    endcase
    b = ($urandom % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // Checks combinational outputs, predicts the next edge, then checks registered outputs.
  task automatic step();
    int g, j, e;
    logic [NREQ-1:0] er;
    #1;
    g = -1;
    if (!rst && !hold) begin
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (g < 0 && req_valid[j[1:0]]) g = j;
      end
    end
    er = '0;
    if (g >= 0) er = NREQ'(1) << g;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("idle", 64'(idle), 64'(m_q.size() == 0 && req_valid == '0));
    last_grant = g;
    e = ecnt + 1;
    if (rst) begin
      m_q.delete();
      m_ptr  = 0;
      e_mvld = 1'b0;
      e_in1  = '0;
      e_in2  = '0;
      e_rv   = '0;
      e_rres = '0;
    end else begin
      e_rv = '0;
      if (m_q.size() > 0 && m_q[0].due == e) begin
        e_rv   = NREQ'(1) << m_q[0].id;
        e_rres = m_q[0].prod;
        void'(m_q.pop_front());
      end
      if (g >= 0) begin
        e_mvld = 1'b1;
        e_in1  = req_a[32*g +: 32];
        e_in2  = req_b[32*g +: 32];
        m_q.push_back('{due: e + LAT + 1, id: g, prod: 64'(e_in1) * 64'(e_in2)});
        m_ptr  = (g + 1) % NR;
      end else begin
        e_mvld = 1'b0;
      end
    end
    ecnt = e;
    @(posedge clk);
    #1;
    chk("mul_vld", 64'(mul_vld), 64'(e_mvld));
    chk("mul_in1", 64'(mul_in1), 64'(e_in1));
    chk("mul_in2", 64'(mul_in2), 64'(e_in2));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_res", rsp_res, e_rres);
    chk("inflight", 64'(inflight), 64'(m_q.size()));
    obs_rv   = rsp_valid;
    obs_rres = rsp_res;
  endtask

  task automatic reset_dut();
    rst = 1'b1; hold = 1'b0; req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t            vt[6];
  int              rr_exp[6];
  logic [NREQ-1:0] rsp_seq[$];
  int              cnt, lat;
  logic            seen;

  initial begin
    rst = 1'b1; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    m_ptr = 0; ecnt = 0; last_grant = -1;
    e_mvld = 1'b0; e_in1 = '0; e_in2 = '0; e_rv = '0; e_rres = '0;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Single-op vector table: constant products, latency of MUL_LAT+1 edges.
    vt[0] = '{2, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vt[1] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vt[2] = '{3, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vt[3] = '{1, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
    vt[4] = '{2, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0};
    vt[5] = '{1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    for (int v = 0; v < 6; v++) begin
      req_valid = '0;
      req_valid[vt[v].id] = 1'b1;
      req_a[32*vt[v].id +: 32] = vt[v].a;
      req_b[32*vt[v].id +: 32] = vt[v].b;
      step();
      chk("vec_grant", 64'(last_grant), 64'(vt[v].id));
      chk("vec_in1", 64'(mul_in1), 64'(vt[v].a));
      req_valid = '0;
      seen = 1'b0; lat = 0;
      for (int c = 1; c <= 8 && !seen; c++) begin
        step();
        if (obs_rv != '0) begin seen = 1'b1; lat = c; end
      end
      chk("vec_rsp_valid", 64'(obs_rv), 64'(NREQ'(1) << vt[v].id));
      chk("vec_rsp_res", obs_rres, vt[v].p);
      chk("vec_latency", 64'(lat), 64'(LAT + 1));
      #1;
      chk("vec_idle", 64'(idle), 64'(1));
    end

    // Round-robin with all requesters continuously valid from reset.
    reset_dut();
    rr_exp = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NR; i++) new_ops(i);
    req_valid = '1;
    rsp_seq.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_grant", 64'(last_grant), 64'(rr_exp[i]));
      if (obs_rv != '0) rsp_seq.push_back(obs_rv);
      if (last_grant >= 0) new_ops(last_grant);
    end
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs_rv != '0) rsp_seq.push_back(obs_rv);
    end
    for (int i = 0; i < 6; i++) begin
      chk("rr_rsp_order", 64'(i < rsp_seq.size() ? rsp_seq[i] : '0), 64'(NREQ'(1) << rr_exp[i]));
    end

    // Hold blocks grants while in-flight ops still retire; requester 1 wins after release.
    reset_dut();
    req_valid = 4'b1000; new_ops(3);
    step();
    new_ops(3);
    step();
    hold = 1'b1; new_ops(1); new_ops(3);
    req_valid = 4'b1010;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_ready", 64'(req_ready), 64'(0));
      step();
      if (obs_rv != '0) cnt++;
    end
    chk("hold_rsp_count", 64'(cnt), 64'(2));
    hold = 1'b0;
    step();
    chk("hold_release_grant", 64'(last_grant), 64'(1));
    drain(6);

    // Ten back-to-back ops: inflight pins at MUL_LAT+1 while issuing and retiring together.
    reset_dut();
    req_valid = 4'b0010;
    new_ops(1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= LAT) chk("stream_inflight", 64'(inflight), 64'(LAT + 1));
      new_ops(1);
    end
    drain(6);
    chk("stream_drained", 64'(inflight), 64'(0));

    // Reset with three ops in flight discards them.
    reset_dut();
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin new_ops(0); step(); end
    req_valid = '0;
    chk("pre_reset_inflight", 64'(inflight), 64'(3));
    rst = 1'b1;
    step();
    req_valid = 4'b1100; new_ops(2); new_ops(3);
    #1;
    chk("reset_ready", 64'(req_ready), 64'(0));
    step();
    rst = 1'b0;
    req_valid = '0;
    cnt = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      if (obs_rv != '0) cnt++;
    end
    chk("post_reset_rsp", 64'(cnt), 64'(0));
    chk("post_reset_inflight", 64'(inflight), 64'(0));
    req_valid = 4'b1100;
    step();
    chk("post_reset_grant", 64'(last_grant), 64'(2));
    drain(6);

    // Random traffic following the requester rules.
    reset_dut();
    for (int t = 0; t < 3000; t++) begin
      hold = ($urandom % 8 == 0);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          new_ops(i);
        end
      end
      step();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
    end
    hold = 1'b0;
    drain(8);
    chk("final_inflight", 64'(inflight), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_arb_sched.md
# mul_arb_sched

Round-robin arbiter and issue scheduler that shares one fixed-latency pipelined 32x32 multiplier among NREQ requesters. Each cycle it accepts at most one operand pair, drives it onto the multiplier input bus, and carries a requester tag through a valid/tag shift register that matches the multiplier latency. It then routes each 64-bit product back to the requester that issued it. It sits between the requesting datapath blocks and the multiplier instance behind the shared multiplier interface.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- MUL_LAT, 3: multiplier latency in cycles from mul_vld/mul_in* sampled at an edge to mul_res valid, 1..8.
- CW, $clog2(MUL_LAT+2): width of the in-flight counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  when high, no new requests are granted; in-flight operations still complete.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*32  packed operand A; requester i occupies [32*i+:32].
- req_b  in  NREQ*32  packed operand B, same packing.
- mul_vld  out  1  operands on mul_in1/mul_in2 are valid.
- mul_in1  out  32  multiplier operand 1, registered.
- mul_in2  out  32  multiplier operand 2, registered.
- mul_res  in  64  multiplier product, valid MUL_LAT cycles after the operands are sampled.
- rsp_valid  out  NREQ  one-hot pulse: product for requester i is on rsp_res.
- rsp_res  out  64  product, registered.
- inflight  out  CW  number of accepted operations whose response has not yet been delivered.
- idle  out  1  high when inflight==0 and req_valid==0.

## Operation
- Arbitration is round-robin. A pointer ptr (0..NREQ-1) marks the highest-priority requester.
  - The grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... with wrap-around.
  - req_ready[i] = grant[i] & ~hold & ~rst. It is combinational from req_valid, ptr and hold.
- A transfer occurs at an edge where req_valid[i] & req_ready[i] = 1. At that edge:
  - ptr becomes (i+1) mod NREQ.
  - mul_in1 <= req_a[i], mul_in2 <= req_b[i], mul_vld <= 1.
  - Stage 0 of the tag pipe <= {1, i}.
- With no transfer: mul_vld <= 0, mul_in1 and mul_in2 hold their values, and ptr holds.
- The tag pipe has MUL_LAT+1 stages of {v, id}. Stage k+1 <= stage k every cycle and shifts unconditionally; there is no stall.
- When the last stage has v=1: rsp_valid <= onehot(id) and rsp_res <= mul_res. Otherwise rsp_valid <= 0 and rsp_res holds.
- Responses have no backpressure. Requesters must accept rsp_valid in the cycle it is asserted.
- inflight increments on a transfer and decrements on a response. If both happen in the same cycle, it is unchanged. It never exceeds MUL_LAT+1.
- Requester rules:
  - A requester must not make req_valid depend on req_ready.
  - Once it raises req_valid, it holds valid and its operands stable until accepted.
  - The block does not check these rules.
- Reset:
  - ptr = 0, tag pipe cleared, and inflight, mul_vld, mul_in1, mul_in2, rsp_valid, rsp_res all 0.
  - idle follows its definition.
  - Operations in flight at reset are discarded; no rsp_valid is produced for them.
  - req_ready = 0 while rst = 1.

## Timing
- Throughput: one operation per cycle sustained, with back-to-back grants allowed to the same or to different requesters.
- Latency: for a transfer at edge T, mul_vld is high in cycle T..T+1, and rsp_valid/rsp_res are high in cycle T+MUL_LAT+1..T+MUL_LAT+2. This is a fixed MUL_LAT+1 edges after acceptance.
- Ordering: responses are delivered in acceptance order.
- hold takes effect in the same cycle it is applied, because req_ready is gated combinationally. Deasserting hold allows a grant in the same cycle.
- Single requester: a single requester with valid held high is granted every cycle regardless of ptr.
- Fairness: with all requesters continuously valid, grants cycle 0, 1, ..., NREQ-1, 0, and each requester waits at most NREQ-1 cycles.

## Test plan
- Single op: with NREQ=4 and MUL_LAT=3, requester 2 sends a=0x0000_0003 and b=0x0000_0005, accepted at edge T. Required: mul_vld=1 with in1=3 and in2=5 in cycle T, and rsp_valid=4'b0100 with rsp_res=15 at edge T+4. inflight goes 1 then 0, and idle returns high.
- Round-robin: all four requesters are valid continuously from reset. Required: grants go 0,1,2,3,0,1 on consecutive cycles, with rsp_valid one-hot in the same order MUL_LAT+1 cycles later.
- Max operands: a=b=0xFFFF_FFFF. Required: rsp_res=0xFFFF_FFFE_0000_0001. Also a=0x8000_0000 with b=2 gives 0x0000_0001_0000_0000.
- Hold: hold is raised while requesters 1 and 3 are valid. Required: req_ready=0 throughout, and in-flight responses still arrive. After hold is released, requester 1 is granted first when ptr=0.
- Simultaneous issue and retire: a stream of 10 back-to-back ops. Required: inflight stays at MUL_LAT+1=4 at steady state and every product matches its requester id.
- Reset mid-operation: rst is asserted with inflight=3, then released. Required: no rsp_valid after reset, inflight=0, ptr=0, and the next grant goes to the lowest valid index.
